// File: rtl/modn_updown_counter.sv
// modn_updown_counter: synchronous modulo-MOD up/down counter with clear, load, tc and wrap.
// Latency: q/wrap/load_err (and g) update one clk edge after sampling; tc is combinational.
// Backpressure: none; counts whenever en is high, cascade by feeding tc into the next en.
// Optional feature macro: COUNTER_GRAY_OUT_EN adds the registered Gray-code output g.
module modn_updown_counter #(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] g
`endif
);

  // Largest legal count value, truncated to the counter width.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);
  // Full-range modulus: wrap is taken from the adder carry/borrow instead of a comparator.
  localparam bit FULL = (MOD == (64'd1 << WIDTH));

  logic             at_max;
  logic             at_zero;
  logic             din_ok;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic [WIDTH-1:0] next_q;
  logic             next_wrap;
  logic             next_err;

  assign at_max  = (q == MAXV);
  assign at_zero = (q == '0);
  assign din_ok  = (din <= MAXV);

  // Extended-width increment/decrement so the top bit is the natural carry/borrow.
  assign inc = {1'b0, q} + (WIDTH + 1)'(1);
  assign dec = {1'b0, q} - (WIDTH + 1)'(1);

  // Terminal count for cascading; must stay combinational so the next stage counts this edge.
  assign tc = en & (up ? at_max : at_zero);

  // Next-state selection with priority clr > load > en > hold.
  always_comb begin
    next_q    = q;
    next_wrap = 1'b0;
    next_err  = 1'b0;
    if (clr) begin
      next_q = '0;
    end else if (load) begin
      if (din_ok) begin
        next_q = din;
      end else begin
        next_q   = MAXV;
        next_err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (FULL) begin
          next_q    = inc[WIDTH-1:0];
          next_wrap = inc[WIDTH];
        end else begin
          next_q    = at_max ? '0 : inc[WIDTH-1:0];
          next_wrap = at_max;
        end
      end else begin
        if (FULL) begin
          next_q    = dec[WIDTH-1:0];
          next_wrap = dec[WIDTH];
        end else begin
          next_q    = at_zero ? MAXV : dec[WIDTH-1:0];
          next_wrap = at_zero;
        end
      end
    end
  end

  // Count, wrap and load-error registers; reset kills any pending pulse immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= next_q;
      wrap     <= next_wrap;
      load_err <= next_err;
    end
  end

`ifdef COUNTER_GRAY_OUT_EN
  // Gray code of the value q takes on this edge, so g and q always line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g <= '0;
    end else begin
      g <= next_q ^ (next_q >> 1);
    end
  end
`endif

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Fully synchronous, parametrised modulo-N up/down counter, the successor to the team's 4-bit ripple up counter. All bits change on the same clock edge (no ripple skew), with runtime direction, synchronous clear, parallel load, terminal-count and wrap outputs for cascading. Used as the general-purpose counter primitive for dividers, timers and address generators.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32.
- MOD, 16: count modulus; legal range 2..2^WIDTH; count sequence is 0..MOD-1.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load of din.
- din  in  WIDTH  load value.
- en  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down; sampled each enabled edge.
- q  out  WIDTH  registered count value.
- tc  out  1  combinational terminal count: en & (up ? q==MOD-1 : q==0).
- wrap  out  1  registered one-cycle pulse; the previous edge wrapped the count.
- load_err  out  1  registered one-cycle pulse; the previous edge loaded an out-of-range din.
- g  out  WIDTH  registered Gray code of q (only with COUNTER_GRAY_OUT_EN).

## Operation
- Reset values: q = 0, wrap = 0, load_err = 0, g = 0; tc follows its equation (0 while en = 0).
- Per-edge priority: clr > load > en > hold.
- clr = 1: q <- 0; wrap <- 0; load_err <- 0.
- load = 1 (clr = 0): if din <= MOD-1, q <- din, load_err <- 0; else q <- MOD-1, load_err <- 1. wrap <- 0. en and up are ignored that edge.
- en = 1, up = 1: q <- (q == MOD-1) ? 0 : q+1; wrap <- (q == MOD-1).
- en = 1, up = 0: q <- (q == 0) ? MOD-1 : q-1; wrap <- (q == 0).
- en = 0, no clr/load: q holds; wrap <- 0; load_err <- 0.
- Arithmetic at WIDTH bits; when MOD = 2^WIDTH, wrap is the natural roll-over (all-ones <-> 0), with no comparator-dependent glitch.
- A direction change takes effect on the next enabled edge; no dead cycle.
- Cascading: the tc of a lower stage drives the en of the next stage; the combined chain counts modulo MOD_lo*MOD_hi in a single cycle.

## Timing
- Latency: q reflects clr, load or count one edge after the inputs are sampled.
- wrap and load_err are asserted for exactly the cycle after the causing edge.
- tc is combinational from q, up and en. Valid within the same cycle for cascade enable; no registered delay.
- rst assertion clears outputs asynchronously, without waiting for clk. Deassertion is assumed synchronous to clk externally. The first count occurs on the first edge with rst low and en high.
- rst mid-count, including on the wrap edge: q = 0 and wrap = 0 immediately; no pending pulse survives.
- Setup/hold on clr, load, din, en and up apply relative to the rising edge of clk only.

## Configuration
- COUNTER_GRAY_OUT_EN defined: output g is present and registered as g <- next_q ^ (next_q >> 1). It updates on the same edge as q, with the same reset and clear behaviour. Gray adjacency is guaranteed only when MOD = 2^WIDTH.
- Not defined: port g and its register are absent; all other behaviour is identical.

## Test plan
- WIDTH = 4, MOD = 10, reset then en = 1, up = 1 for 12 edges -> q = 1..9, 0, 1, 2. wrap is high only in the cycle after q goes 9 -> 0. tc is high while q = 9.
- up = 0 from q = 0 with en = 1 -> q = 9, 8, 7. wrap pulses once after 0 -> 9. tc is high while q = 0.
- load = 1, din = 7 -> q = 7, load_err = 0. load = 1, din = 12 -> q = 9 and a one-cycle load_err. clr and load both high with din = 5 -> q = 0.
- Assert rst asynchronously mid-cycle with q = 6 -> q = 0 before the next edge. With en = 1, rst low -> next edge gives q = 1.
- Two MOD = 10 instances cascaded via tc -> en, for 100 edges -> a 0..99 sequence. The high stage increments only on low-stage 9 -> 0. Both stages are 0 after edge 100.
- With COUNTER_GRAY_OUT_EN, WIDTH = 4, MOD = 16, counting up for 16 edges -> each g transition changes exactly one bit, and g = q ^ (q >> 1) on every cycle.
